// File: rtl/halloween_pkg.sv
// Shared opcode set, builder state encoding and legality check for the
// Halloween decoration player.
package halloween_pkg;

  localparam logic [3:0] OP_ON        = 4'b0000;
  localparam logic [3:0] OP_NOP       = 4'b0001;
  localparam logic [3:0] OP_GREEN     = 4'b0100;
  localparam logic [3:0] OP_PURPLE    = 4'b0101;
  localparam logic [3:0] OP_ORANGE    = 4'b0110;
  localparam logic [3:0] OP_SCREAMING = 4'b1000;
  localparam logic [3:0] OP_CACKLING  = 4'b1001;
  localparam logic [3:0] OP_BOO       = 4'b1010;
  localparam logic [3:0] OP_WAVEHANDS = 4'b1100;
  localparam logic [3:0] OP_MOVEJAW   = 4'b1101;
  localparam logic [3:0] OP_FOG       = 4'b1110;

  typedef enum logic [1:0] {
    FILL,
    SEND,
    HOLD
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ON, OP_NOP, OP_GREEN, OP_PURPLE, OP_ORANGE,
      OP_SCREAMING, OP_CACKLING, OP_BOO,
      OP_WAVEHANDS, OP_MOVEJAW, OP_FOG: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/show_program_builder_if.sv
// Command intake and program handoff signals of the show program builder.
interface show_program_builder_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic        commit;
  logic        prog_valid;
  logic        prog_ready;
  logic [15:0] prog_data;
  logic [2:0]  prog_count;
  logic        err_illegal;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, commit, prog_ready,
    input  cmd_ready, prog_valid, prog_data, prog_count, err_illegal, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, commit, prog_ready,
    output cmd_ready, prog_valid, prog_data, prog_count, err_illegal, busy
  );

endinterface

// File: rtl/halloween_op_check.sv
// Rejects illegal opcodes, and ON in slot 0 (all-zero channel 0 would hold
// the player in reset).
module halloween_op_check
  import halloween_pkg::*;
(
  input  logic [3:0] cmd_op,
  input  logic       slot0,
  output logic       reject
);

  always_comb begin
    reject = !op_is_legal(cmd_op) || (slot0 && (cmd_op == OP_ON));
  end

endmodule

// File: rtl/show_program_builder.sv
// Packs decoration commands into a 4-slot program word, hands it to the
// player and dwells on it for HOLD_CYCLES before accepting more commands.
module show_program_builder
  import halloween_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  show_program_builder_if.slave bus
);

  localparam int unsigned CW = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? '0 : CW'(HOLD_CYCLES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      wr_ptr;
  logic [3:0][3:0] slots;
  logic [3:0][3:0] slots_nxt;
  logic [CW-1:0]   hold_cnt;
  logic            reject;
  logic            accept;
  logic            store;
  logic            go_send;
  logic [2:0]      fill_cnt;

  halloween_op_check u_op_check (
    .cmd_op (bus.cmd_op),
    .slot0  (wr_ptr == 2'd0),
    .reject (reject)
  );

  // Staging view after this cycle's command: stored first, then committed.
  always_comb begin
    accept    = (state == FILL) && bus.cmd_valid;
    store     = accept && !reject;
    fill_cnt  = {1'b0, wr_ptr} + {2'b00, store};
    slots_nxt = slots;
    if (store) slots_nxt[wr_ptr] = bus.cmd_op;
    go_send   = (state == FILL) &&
                ((store && (wr_ptr == 2'd3)) || (bus.commit && (fill_cnt != 3'd0)));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (go_send) state_nxt = SEND;
      SEND:    if (bus.prog_ready) state_nxt = (HOLD_CYCLES == 0) ? FILL : HOLD;
      HOLD:    if (hold_cnt == '0) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= 2'd0;
      slots           <= {4{OP_NOP}};
      bus.prog_data   <= {4{OP_NOP}};
      bus.prog_count  <= 3'd0;
      bus.err_illegal <= 1'b0;
      hold_cnt        <= '0;
    end else begin
      bus.err_illegal <= accept && reject;
      if (go_send) begin
        bus.prog_data  <= slots_nxt;
        bus.prog_count <= fill_cnt;
        slots          <= {4{OP_NOP}};
        wr_ptr         <= 2'd0;
      end else if (store) begin
        slots  <= slots_nxt;
        wr_ptr <= wr_ptr + 2'd1;
      end
      if ((state == SEND) && bus.prog_ready)
        hold_cnt <= HOLD_LOAD;
      else if ((state == HOLD) && (hold_cnt != '0))
        hold_cnt <= hold_cnt - CW'(1);
    end
  end

  assign bus.cmd_ready  = (state == FILL);
  assign bus.prog_valid = (state == SEND);
  assign bus.busy       = (state != FILL);

endmodule

// File: tb/tb_show_program_builder.sv
// Bench for show_program_builder: directed vector table, hand sequences for
// backpressure/dwell/async reset, then random traffic against a queue model.
module tb_show_program_builder;

  localparam int unsigned HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;

  show_program_builder_if bus ();

  show_program_builder #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        cv;
    logic [3:0]  op;
    logic        cm;
    logic        pr;
    logic        rdy;
    logic        val;
    logic [15:0] data;
    logic [2:0]  cnt;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  // {cmd_ready, prog_valid, busy, err_illegal, prog_count, prog_data}
  function automatic logic [22:0] pack_exp(input logic rdy, input logic val, input logic err,
                                           input logic [2:0] cnt, input logic [15:0] data);
    return {rdy, val, ~rdy, err, cnt, data};
  endfunction

  function automatic logic [22:0] observed();
    return {bus.cmd_ready, bus.prog_valid, bus.busy, bus.err_illegal,
            bus.prog_count, bus.prog_data};
  endfunction

  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] act;
    act = observed();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rdy/val/busy/err=%b cnt=%0d data=%h, want rdy/val/busy/err=%b cnt=%0d data=%h",
               name, act[22:19], act[18:16], act[15:0], exp[22:19], exp[18:16], exp[15:0]);
    end
  endtask

  task automatic step(input logic cv, input logic [3:0] op, input logic cm, input logic pr);
    bus.cmd_valid  = cv;
    bus.cmd_op     = op;
    bus.commit     = cm;
    bus.prog_ready = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic cv, input logic [3:0] op, input logic cm, input logic pr,
                     input logic rdy, input logic val, input logic [15:0] data,
                     input logic [2:0] cnt, input logic err);
    vec_t v;
    v.cv = cv; v.op = op; v.cm = cm; v.pr = pr;
    v.rdy = rdy; v.val = val; v.data = data; v.cnt = cnt; v.err = err;
    tbl.push_back(v);
  endtask

  // Reference model: stored commands in a queue, a pending-program flag and
  // a dwell countdown in cycles.
  logic [3:0]  mq[$];
  bit          m_pend;
  int          m_hold;
  logic [15:0] m_data;
  logic [2:0]  m_cnt;
  logic        m_err;

  task automatic model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_hold = 0;
    m_data = 16'h1111;
    m_cnt  = 3'd0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic cv, input logic [3:0] op, input logic cm, input logic pr);
    m_err = 1'b0;
    if (m_pend) begin
      if (pr) begin
        m_pend = 1'b0;
        m_hold = int'(HOLD);
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      if (cv) begin
        if ((op inside {4'h2, 4'h3, 4'h7, 4'hB, 4'hF}) || (op == 4'h0 && mq.size() == 0))
          m_err = 1'b1;
        else
          mq.push_back(op);
      end
      if (mq.size() == 4 || (cm && mq.size() > 0)) begin
        m_data = 16'h1111;
        for (int k = 0; k < mq.size(); k++) m_data[4*k +: 4] = mq[k];
        m_cnt  = 3'(mq.size());
        m_pend = 1'b1;
        mq.delete();
      end
    end
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 4'h0;
    bus.commit     = 1'b0;
    bus.prog_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", pack_exp(1'b1, 1'b0, 1'b0, 3'd0, 16'h1111));
    rst_n = 1'b1;

    // full program, prog_ready high early is ignored until SEND
    add(1, 4'h4, 0, 0,  1, 0, 16'h1111, 3'd0, 0);
    add(1, 4'h5, 0, 0,  1, 0, 16'h1111, 3'd0, 0);
    add(1, 4'hC, 0, 0,  1, 0, 16'h1111, 3'd0, 0);
    add(1, 4'hE, 0, 1,  0, 1, 16'hEC54, 3'd4, 0);
    add(0, 4'h0, 0, 1,  0, 0, 16'hEC54, 3'd4, 0);
    add(1, 4'h4, 1, 0,  0, 0, 16'hEC54, 3'd4, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'hEC54, 3'd4, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'hEC54, 3'd4, 0);
    add(0, 4'h0, 0, 0,  1, 0, 16'hEC54, 3'd4, 0);
    // partial commit
    add(1, 4'hA, 0, 0,  1, 0, 16'hEC54, 3'd4, 0);
    add(0, 4'h0, 1, 0,  0, 1, 16'h111A, 3'd1, 0);
    add(0, 4'h0, 0, 1,  0, 0, 16'h111A, 3'd1, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h111A, 3'd1, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h111A, 3'd1, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h111A, 3'd1, 0);
    add(0, 4'h0, 0, 0,  1, 0, 16'h111A, 3'd1, 0);
    // accept + commit same cycle
    add(1, 4'h6, 1, 0,  0, 1, 16'h1116, 3'd1, 0);
    add(0, 4'h0, 0, 1,  0, 0, 16'h1116, 3'd1, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h1116, 3'd1, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h1116, 3'd1, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h1116, 3'd1, 0);
    add(0, 4'h0, 0, 0,  1, 0, 16'h1116, 3'd1, 0);
    // commit with nothing stored, then rejects
    add(0, 4'h0, 1, 0,  1, 0, 16'h1116, 3'd1, 0);
    add(1, 4'h3, 0, 0,  1, 0, 16'h1116, 3'd1, 1);
    add(1, 4'h0, 0, 0,  1, 0, 16'h1116, 3'd1, 1);
    add(1, 4'h4, 0, 0,  1, 0, 16'h1116, 3'd1, 0);
    add(1, 4'h0, 0, 0,  1, 0, 16'h1116, 3'd1, 0);
    add(0, 4'h0, 1, 0,  0, 1, 16'h1104, 3'd2, 0);
    add(0, 4'h0, 0, 1,  0, 0, 16'h1104, 3'd2, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h1104, 3'd2, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h1104, 3'd2, 0);
    add(0, 4'h0, 0, 0,  0, 0, 16'h1104, 3'd2, 0);
    add(0, 4'h0, 0, 0,  1, 0, 16'h1104, 3'd2, 0);
    // rejected command with commit
    add(1, 4'h7, 1, 0,  1, 0, 16'h1104, 3'd2, 1);
    add(1, 4'h9, 0, 0,  1, 0, 16'h1104, 3'd2, 0);
    add(1, 4'hF, 1, 0,  0, 1, 16'h1119, 3'd1, 1);

    foreach (tbl[i]) begin
      step(tbl[i].cv, tbl[i].op, tbl[i].cm, tbl[i].pr);
      check($sformatf("vec%0d", i),
            pack_exp(tbl[i].rdy, tbl[i].val, tbl[i].err, tbl[i].cnt, tbl[i].data));
    end

    // backpressure: program stays offered and stable, then dwell
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h4, 1'b1, 1'b0);
      check($sformatf("bp%0d", i), pack_exp(1'b0, 1'b1, 1'b0, 3'd1, 16'h1119));
    end
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("bp_handoff", pack_exp(1'b0, 1'b0, 1'b0, 3'd1, 16'h1119));
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      check($sformatf("dwell%0d", i), pack_exp(1'b0, 1'b0, 1'b0, 3'd1, 16'h1119));
    end
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("dwell_end", pack_exp(1'b1, 1'b0, 1'b0, 3'd1, 16'h1119));

    // asynchronous reset in the middle of HOLD
    step(1'b1, 4'h4, 1'b1, 1'b0);
    check("pre_rst_send", pack_exp(1'b0, 1'b1, 1'b0, 3'd1, 16'h1114));
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("pre_rst_hold", pack_exp(1'b0, 1'b0, 1'b0, 3'd1, 16'h1114));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", pack_exp(1'b1, 1'b0, 1'b0, 3'd0, 16'h1111));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'h8, 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b0, 1'b0);
    step(1'b1, 4'hA, 1'b0, 1'b0);
    check("post_rst_fill", pack_exp(1'b1, 1'b0, 1'b0, 3'd0, 16'h1111));
    step(1'b1, 4'hD, 1'b0, 1'b0);
    check("post_rst_prog", pack_exp(1'b0, 1'b1, 1'b0, 3'd4, 16'hDA98));

    // random traffic against the model
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check("rand_reset", pack_exp(1'b1, 1'b0, 1'b0, 3'd0, 16'h1111));
    for (int i = 0; i < 400; i++) begin
      logic       cv;
      logic [3:0] op;
      logic       cm;
      logic       pr;
      cv = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      cm = ($urandom_range(0, 4) == 0);
      pr = ($urandom_range(0, 2) != 0);
      step(cv, op, cm, pr);
      model_step(cv, op, cm, pr);
      check($sformatf("rand%0d", i),
            pack_exp(!m_pend && (m_hold == 0), m_pend, m_err, m_cnt, m_data));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/show_program_builder.md
# show_program_builder

Front-end encoder for the Halloween decoration player. It accepts decoration commands one at a time over a valid/ready handshake and packs them into the 4-channel × 4-bit program word that the player steps through. The word is then handed to the player over a second handshake. The program is held stable for a minimum dwell so that every program plays at least one full loop.

## Interface
- `HOLD_CYCLES`, default 4: minimum cycles the output program is dwelt on after handoff before new commands are accepted. 0 means no dwell.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  builder can accept a command.
- `cmd_op`  in  4  command opcode.
- `commit`  in  1  flush a partially filled program; level-sampled each cycle.
- `prog_valid`  out  1  new program offered to the player.
- `prog_ready`  in  1  player takes the program.
- `prog_data`  out  16  program word; slot k in bits [4k+3:4k]; slot 0 is channel 0.
- `prog_count`  out  3  number of real (non-pad) commands in `prog_data`, 0–4.
- `err_illegal`  out  1  one-cycle pulse: last accepted command was rejected.
- `busy`  out  1  high in SEND or HOLD.

## Operation
- Opcodes:
  - ON 0000, NOP 0001, GREEN 0100, PURPLE 0101, ORANGE 0110, SCREAMING 1000, CACKLING 1001, BOO 1010, WAVEHANDS 1100, MOVEJAW 1101, FOG 1110.
  - 0010, 0011, 0111, 1011 and 1111 are illegal.
- Storage: a staging buffer (4 slots, write pointer `wr_ptr` 0–3) and an output register (`prog_data`, `prog_count`).
  - The output register changes only on entry to SEND.
  - Between programs the player keeps seeing the last program.
- State FILL:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`:
    - Illegal opcode: the handshake completes, nothing is stored, `err_illegal` pulses.
    - ON (0000) while `wr_ptr`=0: rejected the same way. An all-zero channel 0 holds the player in reset. ON is legal in slots 1–3.
    - Legal opcode: written to `slot[wr_ptr]`, then `wr_ptr`+1.
  - Transition to SEND when a legal command fills slot 3, or when `commit`=1 with at least one stored command.
  - On that transition:
    - Unfilled slots are padded with NOP (0001).
    - `prog_data` and `prog_count` are loaded.
    - Staging is cleared to all NOP and `wr_ptr` goes to 0.
  - `commit` with zero stored commands is ignored.
  - Accept and `commit` in the same cycle: the command is stored first, then committed. A rejected command plus `commit` commits only the previously stored commands.
- State SEND:
  - `prog_valid`=1, `cmd_ready`=0.
  - `prog_data` is stable until `prog_ready`.
  - On `prog_ready`: go to HOLD with the counter loaded to `HOLD_CYCLES`-1. If `HOLD_CYCLES`=0, go straight to FILL.
- State HOLD:
  - `cmd_ready`=0, `prog_valid`=0.
  - The counter decrements each cycle; at 0 the block returns to FILL.
- `commit` and `cmd_valid` are ignored outside FILL.

## Timing
- Reset values:
  - state FILL, `wr_ptr`=0, staging all NOP.
  - `cmd_ready`=1, `prog_valid`=0, `prog_data`=16'h1111, `prog_count`=0, `err_illegal`=0, `busy`=0.
- Reset mid-SEND or mid-HOLD: all of the above values apply immediately (async), discarding the pending program.
- `cmd_ready`, `prog_valid` and `busy` are decoded from the state register only; there is no combinational path from any input.
- `prog_data`, `prog_count` and `err_illegal` are registered.
  - Filling edge N: `prog_valid`=1 and the new `prog_data` appear after edge N.
  - Rejecting edge N: `err_illegal` is high for the cycle after edge N.
- Handoff at edge M: `cmd_ready` is back to 1 after edge M+`HOLD_CYCLES`.
- Back-to-back programs are therefore separated by at least `HOLD_CYCLES`+1 cycles.

## Structure
- Shared package `halloween_pkg`:
  - opcode constants OP_ON … OP_FOG and OP_NOP.
  - state enum {FILL, SEND, HOLD}.
  - function `op_is_legal`.
- The player side imports the same package.
- Sub-module `halloween_op_check`: combinational; takes `cmd_op` and `slot0` and returns `reject`.
- Everything else is inline: FSM, staging, and the HOLD counter (width $clog2(`HOLD_CYCLES`+1), minimum 1).

## Test plan
- Full program: ops 0100, 0101, 1100, 1110 on consecutive cycles, `prog_ready`=1 → `prog_data`=16'hEC54, `prog_count`=4, `prog_valid` high one cycle.
- Partial commit: op 1010, then `commit` → `prog_data`=16'h111A, `prog_count`=1.
- Same-cycle accept+commit: op 0110 together with `commit` → 16'h1116, count 1.
- Commit with nothing stored → no `prog_valid`.
- Rejects:
  - op 0011 → `err_illegal` pulse, `wr_ptr` unchanged.
  - op 0000 as first command → `err_illegal` pulse.
  - op 0100 then 0000 then `commit` → 16'h1104, count 2.
- Backpressure and dwell: `prog_ready` held low 5 cycles → `prog_data` stable and `cmd_ready`=0 throughout. With `HOLD_CYCLES`=4 and handoff at edge M, `cmd_ready` rises after edge M+4.
- Reset mid-HOLD: `rst_n` low for 1 cycle → `prog_data`=16'h1111, `prog_count`=0, `cmd_ready`=1 immediately. The next 4 commands build a fresh program.
